// File: rtl/anita4_trig_pkg.sv
// Shared definitions for the ANITA-4 phi-sector coincidence trigger:
// FSM state encoding, coincidence mode constants and counter widths.
package anita4_trig_pkg;

  localparam int unsigned COUNT_W = 16;
  localparam int unsigned DROP_W  = 8;

  // mode_i encoding
  localparam logic MODE_PAIR   = 1'b0;  // sector AND sector+1
  localparam logic MODE_TRIPLE = 1'b1;  // sector AND (sector-1 OR sector+1)

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } trig_state_e;

endpackage

// File: rtl/anita4_phi_coincidence_trigger_if.sv
// Configuration, hit and result bus of the phi-sector coincidence trigger.
// master: the side driving hits and settings (controller / bench).
// slave : the trigger core.
// Hit/config: l1_i, phi_mask_i, win_i, mode_i, holdoff_i, disable_i.
// Results   : trig_o, phi_o, count_o, drop_o, busy_o, scal_o.
interface anita4_phi_coincidence_trigger_if
  import anita4_trig_pkg::*;
#(
  parameter int unsigned NUM_PHI = 16,
  parameter int unsigned NUM_POL = 2,
  parameter int unsigned WIN_W   = 3,
  parameter int unsigned HOLD_W  = 8
);
  localparam int unsigned NB = NUM_POL * NUM_PHI;

  logic [NB-1:0]      l1_i;
  logic [NB-1:0]      phi_mask_i;
  logic [WIN_W-1:0]   win_i;
  logic               mode_i;
  logic [HOLD_W-1:0]  holdoff_i;
  logic               disable_i;
  logic               trig_o;
  logic [NB-1:0]      phi_o;
  logic [COUNT_W-1:0] count_o;
  logic [DROP_W-1:0]  drop_o;
  logic               busy_o;
  logic [NB-1:0]      scal_o;

  modport master (
    output l1_i, phi_mask_i, win_i, mode_i, holdoff_i, disable_i,
    input  trig_o, phi_o, count_o, drop_o, busy_o, scal_o
  );

  modport slave (
    input  l1_i, phi_mask_i, win_i, mode_i, holdoff_i, disable_i,
    output trig_o, phi_o, count_o, drop_o, busy_o, scal_o
  );

endinterface

// File: rtl/anita4_l1_stretch.sv
// Per-sector L1 pulse stretcher. A rising edge on l1_i loads the counter
// with win_i; s1_o stays high for win_i+1 cycles after a one-cycle hit.
// Ports: clk250_i, rst_n_i (async, active-low), l1_i, win_i, s1_o.
module anita4_l1_stretch #(
  parameter int unsigned WIN_W = 3
) (
  input  logic             clk250_i,
  input  logic             rst_n_i,
  input  logic             l1_i,
  input  logic [WIN_W-1:0] win_i,
  output logic             s1_o
);

  logic             l1_q;
  logic [WIN_W-1:0] cnt_q;

  // Edge detect, stretch counter and registered stretched hit
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      l1_q  <= 1'b0;
      cnt_q <= '0;
      s1_o  <= 1'b0;
    end else begin
      l1_q <= l1_i;
      s1_o <= l1_i | (cnt_q != '0);
      if (l1_i && !l1_q) begin
        cnt_q <= win_i;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - WIN_W'(1);
      end
    end
  end

endmodule

// File: rtl/anita4_phi_coincidence_trigger.sv
// ANITA-4 phi-sector coincidence trigger: stretches per-sector L1 hits,
// forms neighbour coincidences per polarisation, and issues one-cycle
// triggers with a programmable post-trigger holdoff.
// Ports: clk250_i, rst_n_i (async, active-low), bus (slave modport of
// anita4_phi_coincidence_trigger_if).
// Build option: ANITA4_TRIG_SCALER_EN enables per-sector scaler strobes
// on scal_o; otherwise scal_o is tied to zero.
module anita4_phi_coincidence_trigger
  import anita4_trig_pkg::*;
#(
  parameter int unsigned NUM_PHI = 16,
  parameter int unsigned NUM_POL = 2,
  parameter int unsigned WIN_W   = 3,
  parameter int unsigned HOLD_W  = 8
) (
  input  logic                              clk250_i,
  input  logic                              rst_n_i,
  anita4_phi_coincidence_trigger_if.slave   bus
);

  localparam int unsigned NB = NUM_POL * NUM_PHI;

  logic [NB-1:0]      s1;
  logic [NB-1:0]      s1_d_q;
  logic [NB-1:0]      pair_c;
  logic [NB-1:0]      pair_q;
  logic               any_c;
  logic               any_q;
  logic               disable_q;

  trig_state_e        state_q, state_n;
  logic [HOLD_W-1:0]  hold_q, hold_n;
  logic               trig_q, trig_n;
  logic [NB-1:0]      phi_q, phi_n;
  logic [COUNT_W-1:0] count_q, count_n;
  logic [DROP_W-1:0]  drop_q, drop_n;
  logic               busy_q, busy_n;

  // Stage 1: one stretcher per sector bit
  for (genvar k = 0; k < int'(NB); k++) begin : g_stretch
    anita4_l1_stretch #(.WIN_W(WIN_W)) u_stretch (
      .clk250_i (clk250_i),
      .rst_n_i  (rst_n_i),
      .l1_i     (bus.l1_i[k]),
      .win_i    (bus.win_i),
      .s1_o     (s1[k])
    );
  end

  // Stage 2 coincidence; neighbours wrap within a polarisation only
  for (genvar p = 0; p < int'(NUM_POL); p++) begin : g_pol
    for (genvar i = 0; i < int'(NUM_PHI); i++) begin : g_phi
      localparam int K  = p * int'(NUM_PHI) + i;
      localparam int UP = p * int'(NUM_PHI) + ((i + 1) % int'(NUM_PHI));
      localparam int DN = p * int'(NUM_PHI) + ((i + int'(NUM_PHI) - 1) % int'(NUM_PHI));
      assign pair_c[K] = ~bus.phi_mask_i[K] & s1[K] &
                         ((bus.mode_i == MODE_TRIPLE) ? (s1[DN] | s1[UP]) : s1[UP]);
    end
  end

  assign any_c = |pair_q;

  // Stage-2 registers; s1_d_q keeps the hit pattern aligned with pair_q
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pair_q    <= '0;
      s1_d_q    <= '0;
      any_q     <= 1'b0;
      disable_q <= 1'b0;
    end else begin
      pair_q    <= pair_c;
      s1_d_q    <= s1;
      any_q     <= any_c;
      disable_q <= bus.disable_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_n;
  end

  // FSM next-state and registered-output next values
  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    trig_n  = 1'b0;
    phi_n   = phi_q;
    count_n = count_q;
    drop_n  = drop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_c && !disable_q) begin
          trig_n  = 1'b1;
          phi_n   = s1_d_q;
          count_n = count_q + COUNT_W'(1);
          hold_n  = bus.holdoff_i;
          if (bus.holdoff_i != '0) state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        hold_n = hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) state_n = ST_IDLE;
        // Blocked coincidences are counted, never extend the holdoff
        if (any_c && !any_q && !disable_q && (drop_q != {DROP_W{1'b1}}))
          drop_n = drop_q + DROP_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n == ST_HOLD);
  end

  // Output and hold-counter registers
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_q  <= '0;
      trig_q  <= 1'b0;
      phi_q   <= '0;
      count_q <= '0;
      drop_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      hold_q  <= hold_n;
      trig_q  <= trig_n;
      phi_q   <= phi_n;
      count_q <= count_n;
      drop_q  <= drop_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.trig_o  = trig_q;
  assign bus.phi_o   = phi_q;
  assign bus.count_o = count_q;
  assign bus.drop_o  = drop_q;
  assign bus.busy_o  = busy_q;

`ifdef ANITA4_TRIG_SCALER_EN
  logic [NB-1:0] scal_q;

  // One strobe per rising edge of each stage-2 coincidence bit
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) scal_q <= '0;
    else          scal_q <= pair_c & ~pair_q;
  end

  assign bus.scal_o = scal_q;
`else
  assign bus.scal_o = '0;
`endif

endmodule

// File: tb/tb_anita4_phi_coincidence_trigger.sv
`timescale 1ns/1ps
module tb_anita4_phi_coincidence_trigger;

  logic clk250;
  logic rst_n;

  anita4_phi_coincidence_trigger_if #(.NUM_PHI(16), .NUM_POL(2), .WIN_W(3), .HOLD_W(8)) bus ();

  anita4_phi_coincidence_trigger #(.NUM_PHI(16), .NUM_POL(2), .WIN_W(3), .HOLD_W(8)) dut (
    .clk250_i (clk250),
    .rst_n_i  (rst_n),
    .bus      (bus)
  );

  initial clk250 = 1'b0;
  always #2 clk250 = ~clk250;

  typedef struct {
    logic [31:0] l1a;
    logic [31:0] l1b;
    int          gap;
    logic [31:0] mask;
    logic        mode;
    logic [2:0]  win;
    int          exp_trigs;
    logic [31:0] exp_phi;
  } vec_t;

  typedef struct {
    int          trigs;
    logic [31:0] phi;
    logic [31:0] count;
  } exp_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];
  exp_t exp_q [$];

  int          checks;
  int          errors;
  logic [31:0] exp_count;
  logic [31:0] exp_drop;
  logic [31:0] last_phi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk250);
  endtask

  // Drive one table vector, collect triggers, compare against the queued expectation
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    int   trigs;
    logic [31:0] phi_seen;
    bus.phi_mask_i = v.mask;
    bus.mode_i     = v.mode;
    bus.win_i      = v.win;
    bus.holdoff_i  = 8'd0;
    e.trigs = v.exp_trigs;
    e.phi   = (v.exp_trigs > 0) ? v.exp_phi : last_phi;
    e.count = exp_count + 32'(v.exp_trigs);
    exp_q.push_back(e);
    trigs    = 0;
    phi_seen = bus.phi_o;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk250);
      if (bus.trig_o) begin
        trigs++;
        phi_seen = bus.phi_o;
      end
      bus.l1_i = ((c == 0) ? v.l1a : 32'h0) | ((c == v.gap) ? v.l1b : 32'h0);
    end
    got = exp_q.pop_front();
    chk($sformatf("vec%0d_trigs", idx), 32'(trigs), 32'(got.trigs));
    chk($sformatf("vec%0d_phi", idx), phi_seen, got.phi);
    chk($sformatf("vec%0d_count", idx), 32'(bus.count_o), got.count);
    exp_count = got.count;
    last_phi  = got.phi;
    bus.phi_mask_i = 32'h0;
    bus.mode_i     = 1'b0;
  endtask

  // Single pair pulse then check the E1 -> trig-after-E3 latency
  task automatic latency_seq(input string tag);
    @(negedge clk250); bus.l1_i = 32'h18;
    @(negedge clk250); bus.l1_i = 32'h0;
    chk({tag, "_trig_e1"}, 32'(bus.trig_o), 32'd0);
    @(negedge clk250);
    chk({tag, "_trig_e2"}, 32'(bus.trig_o), 32'd0);
    @(negedge clk250);
    exp_count++;
    chk({tag, "_trig_e3"}, 32'(bus.trig_o), 32'd1);
    chk({tag, "_phi"}, bus.phi_o, 32'h18);
    chk({tag, "_count"}, 32'(bus.count_o), exp_count);
    last_phi = 32'h18;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int trig_cnt, busy_run, busy_runs, last_trig, min_gap;

    checks = 0; errors = 0;
    exp_count = 0; exp_drop = 0; last_phi = 0;

    //                l1a           l1b     gap mask          mode  win  trigs phi
    vecs[0]  = '{32'h0000_0018, 32'h0,   0, 32'h0,        1'b0, 3'd0, 1, 32'h0000_0018};
    vecs[1]  = '{32'h0000_8001, 32'h0,   0, 32'h0,        1'b0, 3'd0, 1, 32'h0000_8001};
    vecs[2]  = '{32'h8001_0000, 32'h0,   0, 32'h0,        1'b0, 3'd0, 1, 32'h8001_0000};
    vecs[3]  = '{32'h0001_8000, 32'h0,   0, 32'h0,        1'b0, 3'd0, 0, 32'h0};
    vecs[4]  = '{32'h0000_0020, 32'h40,  3, 32'h0,        1'b0, 3'd3, 1, 32'h0000_0060};
    vecs[5]  = '{32'h0000_0020, 32'h40,  4, 32'h0,        1'b0, 3'd3, 0, 32'h0};
    vecs[6]  = '{32'h0000_00C0, 32'h0,   0, 32'h40,       1'b1, 3'd0, 1, 32'h0000_00C0};
    vecs[7]  = '{32'h0000_00C0, 32'h0,   0, 32'hC0,       1'b1, 3'd0, 0, 32'h0};
    vecs[8]  = '{32'h0000_0080, 32'h0,   0, 32'h0,        1'b1, 3'd0, 0, 32'h0};
    vecs[9]  = '{32'h0000_00C0, 32'h0,   0, 32'h0,        1'b0, 3'd0, 1, 32'h0000_00C0};
    vecs[10] = '{32'h0000_8001, 32'h0,   0, 32'h0,        1'b1, 3'd0, 1, 32'h0000_8001};
    vecs[11] = '{32'h0000_0018, 32'h0,   0, 32'h08,       1'b0, 3'd0, 0, 32'h0};
    vecs[12] = '{32'h0000_0018, 32'h0,   0, 32'h08,       1'b1, 3'd0, 1, 32'h0000_0018};

    rst_n = 1'b0;
    bus.l1_i = '0; bus.phi_mask_i = '0; bus.win_i = '0; bus.mode_i = 1'b0;
    bus.holdoff_i = '0; bus.disable_i = 1'b0;
    idle(3);
    chk("rst_trig",  32'(bus.trig_o),  32'd0);
    chk("rst_busy",  32'(bus.busy_o),  32'd0);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_drop",  32'(bus.drop_o),  32'd0);
    chk("rst_phi",   bus.phi_o,        32'd0);
    chk("rst_scal",  bus.scal_o,       32'd0);
    rst_n = 1'b1;
    idle(2);

    // Latency, phi latch and 10-cycle holdoff
    bus.holdoff_i = 8'd10;
    latency_seq("lat");
    chk("lat_busy_0", 32'(bus.busy_o), 32'd1);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk250);
      chk($sformatf("lat_busy_%0d", i), 32'(bus.busy_o), 32'd1);
    end
    @(negedge clk250);
    chk("lat_busy_end", 32'(bus.busy_o), 32'd0);
    idle(3);

    for (int v = 0; v < NVEC; v++) run_vec(vecs[v], v);

    // Holdoff 4 with a pair every 2 cycles for 20 cycles
    bus.holdoff_i = 8'd4;
    idle(2);
    trig_cnt = 0; busy_run = 0; busy_runs = 0; last_trig = -100; min_gap = 1000;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk250);
      if (bus.trig_o) begin
        trig_cnt++;
        if (c - last_trig < min_gap) min_gap = c - last_trig;
        last_trig = c;
      end
      if (bus.busy_o) busy_run++;
      else if (busy_run != 0) begin
        busy_runs++;
        chk($sformatf("hold_busy_run%0d", busy_runs), 32'(busy_run), 32'd4);
        busy_run = 0;
      end
      bus.l1_i = (c < 20 && (c % 2) == 0) ? 32'h18 : 32'h0;
    end
    exp_count += 4;
    exp_drop  += 6;
    chk("hold_trigs", 32'(trig_cnt), 32'd4);
    chk("hold_gap_ge5", 32'(min_gap >= 5), 32'd1);
    chk("hold_busy_runs", 32'(busy_runs), 32'd4);
    chk("hold_drop", 32'(bus.drop_o), exp_drop);
    chk("hold_count", 32'(bus.count_o), exp_count);

    // Disable while idle: no trigger, no count
    bus.holdoff_i = 8'd0;
    bus.disable_i = 1'b1;
    idle(2);
    trig_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk250);
      if (bus.trig_o) trig_cnt++;
      bus.l1_i = (c == 0) ? 32'h18 : 32'h0;
    end
    chk("dis_trigs", 32'(trig_cnt), 32'd0);
    chk("dis_count", 32'(bus.count_o), exp_count);
    bus.disable_i = 1'b0;
    idle(2);

    // Long holdoff: drops gated by disable, then reset mid-HOLD
    bus.holdoff_i = 8'd200;
    @(negedge clk250); bus.l1_i = 32'h18;
    @(negedge clk250); bus.l1_i = 32'h0;
    idle(4);
    exp_count++;
    chk("long_busy", 32'(bus.busy_o), 32'd1);
    chk("long_count", 32'(bus.count_o), exp_count);
    bus.disable_i = 1'b1;
    idle(1);
    bus.l1_i = 32'h18;
    @(negedge clk250); bus.l1_i = 32'h0;
    idle(5);
    chk("long_drop_dis", 32'(bus.drop_o), exp_drop);
    bus.disable_i = 1'b0;
    idle(2);
    bus.l1_i = 32'h18;
    @(negedge clk250); bus.l1_i = 32'h0;
    idle(5);
    exp_drop++;
    chk("long_drop", 32'(bus.drop_o), exp_drop);
    chk("long_busy2", 32'(bus.busy_o), 32'd1);

    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(bus.busy_o),  32'd0);
    chk("arst_count", 32'(bus.count_o), 32'd0);
    chk("arst_drop",  32'(bus.drop_o),  32'd0);
    chk("arst_phi",   bus.phi_o,        32'd0);
    exp_count = 0; exp_drop = 0;
    @(negedge clk250);
    bus.holdoff_i = 8'd0;
    rst_n = 1'b1;
    idle(1);
    latency_seq("post_rst");
    chk("post_rst_busy", 32'(bus.busy_o), 32'd0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
